// File: rtl/pixel_stream_monitor.sv
// Measures line length, line count and a per-frame pixel sum from a pixel stream.
// Optional macro PIXEL_CHECKSUM_EN builds the 16-bit checksum accumulator; without it, checksum reads 0.
module pixel_stream_monitor #(
  parameter int EXP_PIXELS = 640,
  parameter int EXP_LINES  = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  pixel_in,
  input  logic        line_valid,
  input  logic        frame_valid,
  input  logic        clr_err,
  output logic [11:0] pix_cnt_last,
  output logic [11:0] line_cnt_last,
  output logic [15:0] frame_cnt,
  output logic        frame_done,
  output logic        len_err,
  output logic        lines_err,
  output logic        proto_err,
  output logic [15:0] checksum,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    WAIT_FV = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  localparam logic [11:0] CNT_MAX   = 12'hFFF;
  localparam logic [11:0] EXP_PIX_W = 12'(EXP_PIXELS);
  localparam logic [11:0] EXP_LIN_W = 12'(EXP_LINES);

  state_t      state, state_nxt;
  logic        fv_d, lv_d;
  logic [11:0] pix_cnt, line_cnt, last_pix;
  logic        fv_rise, fv_fall, frame_start;
  logic        pix_take, line_close, frame_close;
  logic [11:0] pix_inc, line_inc, frame_pix, frame_lines;

  assign fsm_state = state;

  // Edges compare the live qualifier with its one-cycle-old copy.
  always_comb begin
    fv_rise     = frame_valid & ~fv_d;
    fv_fall     = ~frame_valid & fv_d;
    pix_take    = (state == ACTIVE) & line_valid & frame_valid;
    frame_close = (state == ACTIVE) & fv_fall;
    // An open line is closed by its own falling edge or by the frame ending under it.
    line_close  = (state == ACTIVE) & lv_d & (~line_valid | fv_fall);
    pix_inc     = (pix_cnt == CNT_MAX) ? pix_cnt : pix_cnt + 12'd1;
    line_inc    = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + 12'd1;
    frame_pix   = line_close ? pix_cnt : last_pix;
    frame_lines = line_close ? line_inc : line_cnt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    case (state)
      SYNC:    if (!frame_valid) state_nxt = WAIT_FV;
      WAIT_FV: begin
        if (fv_rise) begin
          state_nxt   = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE:  if (fv_fall) state_nxt = WAIT_FV;
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SYNC;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fv_d          <= 1'b0;
      lv_d          <= 1'b0;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      last_pix      <= '0;
      pix_cnt_last  <= '0;
      line_cnt_last <= '0;
      frame_cnt     <= '0;
      frame_done    <= 1'b0;
      len_err       <= 1'b0;
      lines_err     <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      fv_d       <= frame_valid;
      lv_d       <= line_valid;
      frame_done <= frame_close;
      if (frame_start) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
        last_pix <= '0;
      end else if (line_close) begin
        line_cnt <= line_inc;
        last_pix <= pix_cnt;
        pix_cnt  <= '0;
      end else if (pix_take) begin
        pix_cnt <= pix_inc;
      end
      if (frame_close) begin
        pix_cnt_last  <= frame_pix;
        line_cnt_last <= frame_lines;
        frame_cnt     <= frame_cnt + 16'd1;
      end
      // Sticky flags: a set condition in the clearing cycle wins.
      len_err   <= (line_close & (pix_cnt != EXP_PIX_W)) | (len_err & ~clr_err);
      lines_err <= (frame_close & (frame_lines != EXP_LIN_W)) | (lines_err & ~clr_err);
      proto_err <= (line_valid & ~frame_valid) | (proto_err & ~clr_err);
    end
  end

`ifdef PIXEL_CHECKSUM_EN
  logic [15:0] acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      checksum <= '0;
    end else begin
      if (frame_start)   acc <= '0;
      else if (pix_take) acc <= acc + {6'd0, pixel_in};
      if (frame_close)   checksum <= acc;
    end
  end
`else
  logic pixel_unused;
  assign pixel_unused = ^pixel_in;
  assign checksum     = '0;
`endif

endmodule

// File: doc/pixel_stream_monitor.md
PIXEL_STREAM_MONITOR -- requirements
Module: pixel_stream_monitor

Interface
REQ-001 Parameter EXP_PIXELS, default 640, expected active pixels per line (1..4095).
REQ-002 Parameter EXP_LINES, default 480, expected lines per frame (1..4095).
REQ-003 clk  in  1  pixel clock, the same clock that drives the test pattern generator; all logic SHALL be on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 pixel_in  in  10  pixel data, valid when line_valid=1 and frame_valid=1.
REQ-006 line_valid  in  1  active-line qualifier.
REQ-007 frame_valid  in  1  active-frame qualifier.
REQ-008 clr_err  in  1  synchronous clear of the sticky error flags.
REQ-009 pix_cnt_last  out  12  pixel count of the last line of the last completed frame.
REQ-010 line_cnt_last  out  12  line count of the last completed frame.
REQ-011 frame_cnt  out  16  number of completed frames; wraps modulo 2^16.
REQ-012 frame_done  out  1  one-cycle pulse when the results above update.
REQ-013 len_err  out  1  sticky flag: a line length differed from EXP_PIXELS.
REQ-014 lines_err  out  1  sticky flag: a frame line count differed from EXP_LINES.
REQ-015 proto_err  out  1  sticky flag: line_valid=1 was seen while frame_valid=0.
REQ-016 checksum  out  16  per-frame pixel sum (see Configuration).

Function
REQ-017 frame_valid and line_valid SHALL be registered once (fv_d, lv_d); edges are detected as current sample versus the registered sample.
REQ-018 The FSM SHALL have three states: SYNC, WAIT_FV and ACTIVE; it SHALL enter SYNC at reset.
REQ-019 SYNC: on any cycle with frame_valid=0, go to WAIT_FV; a frame already in progress at reset release SHALL be ignored.
REQ-020 WAIT_FV: on a frame_valid rising edge, go to ACTIVE and clear the pixel counter, line counter and checksum accumulator.
REQ-021 ACTIVE: each cycle with line_valid=1, the pixel counter SHALL increment, saturating at 4095.
REQ-022 ACTIVE, line_valid falling edge: the line counter SHALL increment (saturating at 4095), the pixel count SHALL be compared with EXP_PIXELS (mismatch sets len_err), and the pixel counter SHALL be held as the last-line count and then cleared.
REQ-023 ACTIVE, frame_valid falling edge: if a line is open (lv_d=1), it SHALL be closed in the same cycle per REQ-022. Then, on the same edge:
- line_cnt_last and pix_cnt_last are loaded;
- checksum is loaded (when enabled);
- frame_cnt increments;
- line_cnt_last≠EXP_LINES sets lines_err;
- the FSM returns to WAIT_FV.
REQ-024 frame_done SHALL be high for exactly the one cycle in which the updated values from REQ-023 are first visible.
REQ-025 In any state, line_valid=1 with frame_valid=0 SHALL set proto_err; that pixel SHALL NOT be counted.
REQ-026 clr_err=1 SHALL clear all sticky flags on the next edge; if a flag's set condition occurs in the same cycle, set wins.
REQ-027 Count and error logic SHALL be gated only by valid signals; pixel_in values SHALL have no effect on any output except checksum.

Reset
REQ-028 While reset_n=0: all outputs, counters, edge registers and the accumulator SHALL be 0, and the FSM SHALL be in SYNC.
REQ-029 Assertion of reset_n mid-frame SHALL discard the partial frame; no frame_done is issued for it.

Configuration
REQ-030 Macro PIXEL_CHECKSUM_EN:
- Defined: a 16-bit accumulator SHALL add zero-extended pixel_in on each counted pixel, modulo 2^16, and SHALL be latched to checksum per REQ-023.
- Undefined: no accumulator is built and checksum SHALL be tied to 0.

Verification (EXP_PIXELS=8, EXP_LINES=4, PIXEL_CHECKSUM_EN defined)
REQ-031 Nominal frame: 4 lines × 8 pixels, pixel_in=10, 2-cycle line gaps -> one frame_done pulse; pix_cnt_last=8, line_cnt_last=4, frame_cnt=1, checksum=320, all error flags 0.
REQ-032 Line 2 has 7 pixels -> len_err=1 after that line ends; line_cnt_last=4; lines_err=0; pulse clr_err -> len_err=0.
REQ-033 frame_valid already high at reset release, then a full frame -> the first partial frame is ignored; frame_cnt=1 only after the second frame_valid falling edge.
REQ-034 line_valid and frame_valid fall in the same cycle on line 4 -> line counted; line_cnt_last=4; lines_err=0.
REQ-035 line_valid=1 for 3 cycles with frame_valid=0 -> proto_err=1, and the next frame's counts are unaffected; clr_err asserted in the same cycle as a new violation -> proto_err stays 1.
REQ-036 reset_n pulsed low during line 3 -> all outputs 0 and no frame_done for the partial frame; the following full frame gives frame_cnt=1.
